// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues one AR/R read at a time and
// hands the fetched instruction to IF/ID; redirects discard wrong-path fetches.
module ifu_fetch #(
  parameter int unsigned     PC_W     = 32,
  parameter int unsigned     INST_W   = 32,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(32'h8000_0000)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              redirect_valid_i,
  input  logic [PC_W-1:0]   redirect_pc_i,
  output logic              arvalid_o,
  output logic [PC_W-1:0]   araddr_o,
  input  logic              arready_i,
  input  logic              rvalid_i,
  input  logic [INST_W-1:0] rdata_i,
  input  logic [1:0]        rresp_i,
  output logic              rready_o,
  output logic [INST_W-1:0] f_inst_o,
  output logic [PC_W-1:0]   f_pc_o,
  output logic              f_fault_o,
  output logic              f_valid_o,
  input  logic              D_ready_i
);

  localparam logic [1:0] S_REQ  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]        state, state_n;
  logic [PC_W-1:0]   pc, pc_n;
  logic [PC_W-1:0]   addr_q;
  logic [PC_W-1:0]   redir_pc;
  logic              kill, kill_n;
  logic              run;
  logic              cap;
  logic              ar_fire;
  logic [INST_W-1:0] inst_q;
  logic [PC_W-1:0]   ipc_q;
  logic              fault_q;

  assign redir_pc  = redirect_pc_i & ~PC_W'(3);
  assign arvalid_o = run && (state == S_REQ);
  assign araddr_o  = addr_q;
  assign rready_o  = (state == S_WAIT);
  assign f_valid_o = (state == S_HOLD);
  assign f_inst_o  = f_valid_o ? inst_q : '0;
  assign f_pc_o    = f_valid_o ? ipc_q : '0;
  assign f_fault_o = f_valid_o && fault_q;
  assign ar_fire   = arvalid_o && arready_i;

  always_comb begin
    state_n = state;
    pc_n    = pc;
    kill_n  = kill;
    cap     = 1'b0;
    case (state)
      S_REQ: begin
        if (ar_fire) state_n = S_WAIT;
        // A presented request must still complete, so it is marked for dropping.
        if (redirect_valid_i) begin
          pc_n   = redir_pc;
          kill_n = run;
        end
      end
      S_WAIT: begin
        if (rvalid_i) begin
          if (redirect_valid_i || kill) begin
            state_n = S_REQ;
            kill_n  = 1'b0;
          end else begin
            cap     = 1'b1;
            pc_n    = pc + PC_W'(4);
            state_n = S_HOLD;
          end
        end else if (redirect_valid_i) begin
          kill_n = 1'b1;
        end
        if (redirect_valid_i) pc_n = redir_pc;
      end
      S_HOLD: begin
        if (D_ready_i || redirect_valid_i) state_n = S_REQ;
        if (redirect_valid_i) pc_n = redir_pc;
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= S_REQ;
      pc      <= RESET_PC;
      addr_q  <= RESET_PC;
      kill    <= 1'b0;
      run     <= 1'b0;
      inst_q  <= '0;
      ipc_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      run   <= 1'b1;
      state <= state_n;
      pc    <= pc_n;
      kill  <= kill_n;
      // Address is frozen while presented; it tracks the PC in every other cycle.
      if (state != S_REQ || !run) addr_q <= pc_n;
      if (cap) begin
        inst_q  <= rdata_i;
        ipc_q   <= pc;
        fault_q <= (rresp_i != 2'b00);
      end
    end
  end

endmodule
